// File: rtl/eim_mini_master.sv
// EIM initiator: one valid/ready request becomes one 8-bit multiplexed address/data
// EIM cycle (ADDR, GAP, DATA, HOLD). Optional responder wait-stretch: define EIM_WAIT_EN.
module eim_mini_master #(
  parameter int PHASE_CYCLES = 4,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       eim_bclk,
  output logic       eim_cs0_n,
  output logic       eim_lba_n,
  output logic       eim_wr_n,
  output logic       eim_oe_n,
  input  logic       eim_wait_n,
  output logic [7:0] eim_da_out,
  output logic       eim_da_oe,
  input  logic [7:0] eim_da_in
);

  if (PHASE_CYCLES < 2 || PHASE_CYCLES > 255) begin : g_bad_phase
    $error("eim_mini_master: PHASE_CYCLES must be 2..255");
  end
  if (WAIT_TIMEOUT < 1 || WAIT_TIMEOUT > 255) begin : g_bad_timeout
    $error("eim_mini_master: WAIT_TIMEOUT must be 1..255");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    HOLD
  } state_t;

  localparam logic [7:0] LAST = 8'(PHASE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic       lat_write;
  logic [7:0] lat_addr, lat_wdata;

  logic       accept;
  logic       frozen;
  logic       timeout_hit;
  logic       timed_out;
  logic       phase_end;
  logic       hold_done;

  // Transaction fields as seen by the output decode: live request on the accept edge.
  logic       t_write;
  logic [7:0] t_addr, t_wdata;

  logic       cs0_n_nxt, lba_n_nxt, wr_n_nxt, oe_n_nxt, da_oe_nxt;
  logic [7:0] da_out_nxt;

  assign accept    = req_valid && req_ready;
  assign phase_end = (cnt == LAST) && !frozen;
  assign hold_done = (state == HOLD) && (cnt == LAST);

`ifdef EIM_WAIT_EN
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);

  logic [WW-1:0] wait_cnt;
  logic          to_flag;

  // The responder is clk-synchronous, so eim_wait_n is used without a synchronizer.
  assign frozen      = (state == DATA) && !eim_wait_n;
  assign timeout_hit = frozen && (wait_cnt == WW'(WAIT_TIMEOUT - 1));
  assign timed_out   = to_flag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else if (accept) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else if (frozen) begin
      wait_cnt <= wait_cnt + WW'(1);
      if (timeout_hit) to_flag <= 1'b1;
    end
  end
`else
  logic unused_wait;
  assign unused_wait = eim_wait_n;
  assign frozen      = 1'b0;
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; otherwise a latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = ADDR;
      end
      ADDR, GAP, HOLD: begin
        if (cnt == LAST) begin
          cnt_nxt = '0;
          unique case (state)
            ADDR:    state_nxt = GAP;
            GAP:     state_nxt = DATA;
            default: state_nxt = IDLE;
          endcase
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DATA: begin
        if (timeout_hit || phase_end) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else if (!frozen) begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    t_write = (state == IDLE) ? req_write : lat_write;
    t_addr  = (state == IDLE) ? req_addr  : lat_addr;
    t_wdata = (state == IDLE) ? req_wdata : lat_wdata;

    cs0_n_nxt  = 1'b1;
    lba_n_nxt  = 1'b1;
    wr_n_nxt   = 1'b1;
    oe_n_nxt   = 1'b1;
    da_oe_nxt  = 1'b0;
    da_out_nxt = '0;
    unique case (state_nxt)
      IDLE: ;
      ADDR: begin
        cs0_n_nxt  = 1'b0;
        lba_n_nxt  = 1'b0;
        da_oe_nxt  = 1'b1;
        da_out_nxt = t_addr;
      end
      GAP, HOLD: begin
        cs0_n_nxt = 1'b0;
        if (t_write) begin
          da_oe_nxt  = 1'b1;
          da_out_nxt = t_wdata;
        end
      end
      DATA: begin
        cs0_n_nxt = 1'b0;
        if (t_write) begin
          wr_n_nxt   = 1'b0;
          da_oe_nxt  = 1'b1;
          da_out_nxt = t_wdata;
        end else begin
          oe_n_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Pins are registered from the next-state decode so they change exactly on phase edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      eim_cs0_n  <= 1'b1;
      eim_lba_n  <= 1'b1;
      eim_wr_n   <= 1'b1;
      eim_oe_n   <= 1'b1;
      eim_bclk   <= 1'b0;
      eim_da_oe  <= 1'b0;
      eim_da_out <= '0;
    end else begin
      req_ready  <= (state_nxt == IDLE);
      eim_cs0_n  <= cs0_n_nxt;
      eim_lba_n  <= lba_n_nxt;
      eim_wr_n   <= wr_n_nxt;
      eim_oe_n   <= oe_n_nxt;
      eim_bclk   <= (state_nxt == IDLE) ? 1'b0 : ~eim_bclk;
      eim_da_oe  <= da_oe_nxt;
      eim_da_out <= da_out_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= hold_done;
      rsp_err   <= hold_done && timed_out;
      // Sampled while oe_n is still low; a timed-out read reports all-ones instead.
      if (state == DATA && !lat_write) begin
        if (timeout_hit)    rsp_rdata <= 8'hFF;
        else if (phase_end) rsp_rdata <= eim_da_in;
      end
    end
  end

endmodule

// File: tb/tb_eim_mini_master.sv
// Self-checking bench for eim_mini_master: table vectors, hand sequences and random
// traffic against a bus-level responder and a phase-timing reference model.
module tb_eim_mini_master;

  localparam int P  = 4;
  localparam int TO = 8;
  localparam int LOGN = 8192;
`ifdef EIM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       eim_bclk, eim_cs0_n, eim_lba_n, eim_wr_n, eim_oe_n;
  logic       eim_wait_n;
  logic [7:0] eim_da_out, eim_da_in;
  logic       eim_da_oe;

  eim_mini_master #(.PHASE_CYCLES(P), .WAIT_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .eim_bclk(eim_bclk), .eim_cs0_n(eim_cs0_n), .eim_lba_n(eim_lba_n),
    .eim_wr_n(eim_wr_n), .eim_oe_n(eim_oe_n), .eim_wait_n(eim_wait_n),
    .eim_da_out(eim_da_out), .eim_da_oe(eim_da_oe), .eim_da_in(eim_da_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       cs0_n;
    logic       lba_n;
    logic       wr_n;
    logic       oe_n;
    logic       bclk;
    logic       da_oe;
    logic [7:0] da_out;
    logic       req_ready;
    logic       rsp_valid;
  } bus_t;

  localparam bus_t IDLE_BUS = '{cs0_n: 1'b1, lba_n: 1'b1, wr_n: 1'b1, oe_n: 1'b1, bclk: 1'b0,
                                da_oe: 1'b0, da_out: 8'h00, req_ready: 1'b1, rsp_valid: 1'b0};

  typedef struct {
    bit         write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Per-cycle record of DUT pins, indexed by cycle number.
  int         cyc = 0;
  bus_t       log_bus [LOGN];
  logic       log_err [LOGN];
  logic [7:0] log_rd  [LOGN];

  // Responder model and plain reference memory.
  logic [7:0] resp_mem [256];
  logic [7:0] ref_mem  [256];
  logic [7:0] r_addr = 8'h00;
  logic       prev_wr_n = 1'b1;
  logic [7:0] last_rd = 8'h00;

  // Wait plan, in cycles relative to the acceptance cycle.
  int acc_cyc   = -100000;
  int wait_from = 0;
  int wait_len  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int rel;
    #1;
    cyc++;
    if (cyc >= LOGN) begin
      $display("FAIL log_overflow: got cycle %0d, expected < %0d", cyc, LOGN);
      $fatal(1);
    end
    log_bus[cyc] = '{cs0_n: eim_cs0_n, lba_n: eim_lba_n, wr_n: eim_wr_n, oe_n: eim_oe_n,
                     bclk: eim_bclk, da_oe: eim_da_oe, da_out: eim_da_out,
                     req_ready: req_ready, rsp_valid: rsp_valid};
    log_err[cyc] = rsp_err;
    log_rd[cyc]  = rsp_rdata;
    if (!eim_cs0_n && !eim_lba_n) r_addr = eim_da_out;
    if (!eim_cs0_n && !prev_wr_n && eim_wr_n && eim_da_oe) resp_mem[r_addr] = eim_da_out;
    prev_wr_n = eim_wr_n;
    eim_da_in = !eim_oe_n ? resp_mem[r_addr] : 8'($urandom);
    rel = cyc - acc_cyc;
    eim_wait_n = !(rel >= wait_from && rel < wait_from + wait_len);
  end

  // DATA length from the wait rules: frozen cycles add, the TO-th frozen cycle ends DATA.
  function automatic int data_len(input int wfrom, input int wlen, output bit to);
    to = 1'b0;
    if (!WAIT_EN || wlen == 0) return P;
    if (wlen >= TO) begin
      to = 1'b1;
      return (wfrom - (2 * P + 1)) + TO;
    end
    return P + wlen;
  endfunction

  function automatic bus_t exp_bus(input int r, input bit w, input logic [7:0] a,
                                   input logic [7:0] d, input int dlen);
    bus_t e;
    int   end_r;
    end_r = 3 * P + dlen;
    e = IDLE_BUS;
    if (r >= 1 && r <= end_r) begin
      e.cs0_n     = 1'b0;
      e.req_ready = 1'b0;
      e.bclk      = (r % 2) == 1;
      if (r <= P) begin
        e.lba_n  = 1'b0;
        e.da_oe  = 1'b1;
        e.da_out = a;
      end else if (w) begin
        e.da_oe  = 1'b1;
        e.da_out = d;
      end
      if (r > 2 * P && r <= 2 * P + dlen) begin
        if (w) e.wr_n = 1'b0;
        else   e.oe_n = 1'b0;
      end
    end
    if (r == end_r + 1) e.rsp_valid = 1'b1;
    return e;
  endfunction

  // Present a request at a negedge; returns at the negedge of the accepting cycle.
  task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int k = 0; k < 50; k++) begin
      if (log_bus[cyc].req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept", 32'(ok), 32'd1);
    acc_cyc = cyc;
  endtask

  task automatic drop_req();
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Wait for rsp_valid, then check latency, pin timeline and response fields.
  task automatic finish_txn(input bit w, input logic [7:0] a, input logic [7:0] d,
                            input int dlen, input bit exp_err, input logic [7:0] exp_rd,
                            output int rc);
    bit   got;
    bus_t act, e;
    got = 1'b0;
    rc  = cyc;
    for (int k = 0; k < 200; k++) begin
      if (cyc > acc_cyc && log_bus[cyc].rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    wait_len = 0;
    check("rsp_seen", 32'(got), 32'd1);
    if (!got) return;
    rc = cyc;
    check("latency", 32'(rc - acc_cyc), 32'(3 * P + dlen + 1));
    for (int r = 1; r <= 3 * P + dlen + 1; r++) begin
      act = log_bus[acc_cyc + r];
      e   = exp_bus(r, w, a, d, dlen);
      if (!e.da_oe) act.da_out = 8'h00;
      check($sformatf("timeline_r%0d", r), 32'(act), 32'(e));
      if (act !== e) break;
    end
    check("rsp_err", 32'(log_err[rc]), 32'(exp_err));
    if (!w) begin
      check("rsp_rdata", 32'(log_rd[rc]), 32'(exp_rd));
      last_rd = exp_rd;
    end else begin
      check("rdata_held", 32'(log_rd[rc]), 32'(last_rd));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish by 200000");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    int   rc, rc1, dl, oe_cnt, rv_cnt;
    bit   to, w;
    logic [7:0] a, d, exp_rd;

    vecs[0] = '{write: 1'b1, addr: 8'h00, wdata: 8'hA5, exp_rdata: 8'h00};
    vecs[1] = '{write: 1'b0, addr: 8'h00, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[2] = '{write: 1'b1, addr: 8'hFF, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[3] = '{write: 1'b1, addr: 8'h80, wdata: 8'h01, exp_rdata: 8'h00};
    vecs[4] = '{write: 1'b0, addr: 8'hFF, wdata: 8'h33, exp_rdata: 8'h5A};
    vecs[5] = '{write: 1'b0, addr: 8'h80, wdata: 8'h00, exp_rdata: 8'h01};
    vecs[6] = '{write: 1'b1, addr: 8'h7F, wdata: 8'h00, exp_rdata: 8'h00};
    vecs[7] = '{write: 1'b0, addr: 8'h7F, wdata: 8'hFF, exp_rdata: 8'h00};

    for (int i = 0; i < 256; i++) begin
      resp_mem[i] = 8'(i) ^ 8'h3C;
      ref_mem[i]  = 8'(i) ^ 8'h3C;
    end
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    eim_wait_n = 1'b1; eim_da_in = 8'h00;

    repeat (3) @(negedge clk);
    check("reset_bus", 32'(log_bus[cyc]), 32'(IDLE_BUS));
    check("reset_rsp_err", 32'(log_err[cyc]), 32'd0);
    check("reset_rsp_rdata", 32'(log_rd[cyc]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors, no waits.
    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      drop_req();
      finish_txn(vecs[i].write, vecs[i].addr, vecs[i].wdata, P, 1'b0, vecs[i].exp_rdata, rc);
      if (vecs[i].write) ref_mem[vecs[i].addr] = vecs[i].wdata;
      @(negedge clk);
    end
    check("resp_mem0", 32'(resp_mem[0]), 32'h0000_00A5);

    // Back-to-back write then read, with req_* changed while the write is in flight.
    issue(1'b1, 8'h01, 8'h03);
    @(negedge clk);
    req_write = 1'b0; req_addr = 8'h01; req_wdata = 8'hEE;
    finish_txn(1'b1, 8'h01, 8'h03, P, 1'b0, 8'h00, rc1);
    ref_mem[1] = 8'h03;
    issue(1'b0, 8'h01, 8'hEE);
    check("b2b_accept_cycle", 32'(acc_cyc), 32'(rc1));
    drop_req();
    finish_txn(1'b0, 8'h01, 8'hEE, P, 1'b0, 8'h03, rc);
    check("b2b_cs_gap", {29'd0, log_bus[rc1 - 1].cs0_n, log_bus[rc1].cs0_n, log_bus[rc1 + 1].cs0_n},
          32'b010);
    @(negedge clk);

    // Wait stretch: 6 wait cycles from the start of a read's DATA phase.
    wait_from = 2 * P + 1; wait_len = 6;
    dl = data_len(wait_from, wait_len, to);
    issue(1'b0, 8'h00, 8'h00);
    drop_req();
    finish_txn(1'b0, 8'h00, 8'h00, dl, 1'b0, 8'hA5, rc);
    oe_cnt = 0;
    for (int c = acc_cyc + 1; c < rc; c++) if (!log_bus[c].oe_n) oe_cnt++;
    check("wait_oe_len", 32'(oe_cnt), WAIT_EN ? 32'd10 : 32'd4);
    check("wait_latency", 32'(rc - acc_cyc), WAIT_EN ? 32'd23 : 32'd17);
    @(negedge clk);

    // Wait held indefinitely on a read: timeout when the feature is built in.
    wait_from = 2 * P + 1; wait_len = 1000;
    dl = data_len(wait_from, wait_len, to);
    issue(1'b0, 8'h00, 8'h00);
    drop_req();
    finish_txn(1'b0, 8'h00, 8'h00, dl, to, to ? 8'hFF : 8'hA5, rc);
    check("timeout_latency", 32'(rc - acc_cyc), WAIT_EN ? 32'd21 : 32'd17);
    @(negedge clk);

    // Random traffic against the reference memory.
    for (int n = 0; n < 30; n++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        wait_from = 2 * P + 1 + int'($urandom_range(0, P - 1));
        wait_len  = int'($urandom_range(1, 10));
      end else begin
        wait_len = 0;
      end
      dl = data_len(wait_from, wait_len, to);
      exp_rd = (to && !w) ? 8'hFF : ref_mem[a];
      issue(w, a, d);
      drop_req();
      finish_txn(w, a, d, dl, to, exp_rd, rc);
      if (w) ref_mem[a] = d;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during the DATA phase of a write.
    @(negedge clk);
    issue(1'b1, 8'h40, 8'h77);
    drop_req();
    while (cyc < acc_cyc + 2 * P + 2) @(negedge clk);
    check("pre_reset_wr_low", 32'(log_bus[cyc].wr_n), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset_bus", 32'(log_bus[cyc]), 32'(IDLE_BUS));
    check("mid_reset_rdata", 32'(log_rd[cyc]), 32'd0);
    rst_n = 1'b1;
    rv_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (log_bus[cyc].rsp_valid) rv_cnt++;
    end
    check("no_rsp_after_abort", 32'(rv_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
